// File: rtl/fetch_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_pipe : PC, fetch addressing and FD/X/MW pipeline registers (RV32I)
// Revision    : 1.0
// ---------------------------------------------------------------------------
module fetch_pipe #(
  parameter logic [31:0] RESET_PC = 32'h4000_0000,
  parameter int          BIOS_AW  = 12,
  parameter int          IMEM_AW  = 14,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic [1:0]         pc_sel,
  input  logic [31:0]        jal_target,
  input  logic [31:0]        alu_out,
  input  logic [31:0]        bios_dout,
  input  logic [31:0]        imem_dout,
  input  logic               cnt_clr,
  output logic [BIOS_AW-1:0] bios_addr,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic               inst_sel,
  output logic [31:0]        inst_fd,
  output logic [31:0]        inst_x,
  output logic [31:0]        inst_mw,
  output logic [31:0]        pc_fd,
  output logic [31:0]        pc_x,
  output logic [31:0]        pc_mw,
  output logic [31:0]        cycle_cnt,
  output logic [31:0]        instret_cnt
);

  logic [31:0] pc_fd_q, pc_fd_d, pc_x_q, pc_x_d, pc_mw_q, pc_mw_d;
  logic [31:0] inst_x_q, inst_x_d, inst_mw_q, inst_mw_d;
  logic        valid_x_q, valid_x_d, valid_mw_q, valid_mw_d;
  logic        kill_fd_q, kill_fd_d, inst_sel_q, inst_sel_d;
  logic [31:0] cycle_q, cycle_d, instret_q, instret_d;
  logic [31:0] fetch_pc;
  logic [31:0] inst_fd_w;
  logic        unused_alu_lsb;

  assign unused_alu_lsb = alu_out[0];

  // Reset forces RESET_PC so the BIOS word is already in flight on release.
  always_comb begin
    if (rst) begin
      fetch_pc = RESET_PC;
    end else if (stall) begin
      fetch_pc = pc_fd_q;
    end else begin
      case (pc_sel)
        2'd0:    fetch_pc = jal_target;
        2'd1:    fetch_pc = {alu_out[31:1], 1'b0};
        default: fetch_pc = pc_fd_q + 32'd4;
      endcase
    end
  end

  assign inst_fd_w = kill_fd_q ? NOP : (inst_sel_q ? bios_dout : imem_dout);

  always_comb begin
    pc_fd_d    = pc_fd_q;
    pc_x_d     = pc_x_q;
    pc_mw_d    = pc_mw_q;
    inst_x_d   = inst_x_q;
    inst_mw_d  = inst_mw_q;
    valid_x_d  = valid_x_q;
    valid_mw_d = valid_mw_q;
    kill_fd_d  = kill_fd_q;
    inst_sel_d = inst_sel_q;
    if (!stall) begin
      pc_fd_d    = fetch_pc;
      inst_sel_d = fetch_pc[30];
      kill_fd_d  = 1'b0;
      // An X-stage redirect squashes the wrong-path instruction sitting in FD.
      if (pc_sel == 2'd1) begin
        inst_x_d  = NOP;
        valid_x_d = 1'b0;
      end else begin
        inst_x_d  = inst_fd_w;
        valid_x_d = ~kill_fd_q;
      end
      pc_x_d     = pc_fd_q;
      inst_mw_d  = inst_x_q;
      pc_mw_d    = pc_x_q;
      valid_mw_d = valid_x_q;
    end
  end

  always_comb begin
    cycle_d   = cycle_q + 32'd1;
    instret_d = (!stall && valid_mw_q) ? instret_q + 32'd1 : instret_q;
    if (cnt_clr) begin
      cycle_d   = 32'd0;
      instret_d = 32'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_fd_q    <= RESET_PC - 32'd4;
      kill_fd_q  <= 1'b1;
      inst_sel_q <= 1'b1;
      inst_x_q   <= NOP;
      inst_mw_q  <= NOP;
      pc_x_q     <= 32'd0;
      pc_mw_q    <= 32'd0;
      valid_x_q  <= 1'b0;
      valid_mw_q <= 1'b0;
      cycle_q    <= 32'd0;
      instret_q  <= 32'd0;
    end else begin
      pc_fd_q    <= pc_fd_d;
      kill_fd_q  <= kill_fd_d;
      inst_sel_q <= inst_sel_d;
      inst_x_q   <= inst_x_d;
      inst_mw_q  <= inst_mw_d;
      pc_x_q     <= pc_x_d;
      pc_mw_q    <= pc_mw_d;
      valid_x_q  <= valid_x_d;
      valid_mw_q <= valid_mw_d;
      cycle_q    <= cycle_d;
      instret_q  <= instret_d;
    end
  end

  assign bios_addr   = fetch_pc[BIOS_AW+1:2];
  assign imem_addr   = fetch_pc[IMEM_AW+1:2];
  assign inst_sel    = inst_sel_q;
  assign inst_fd     = inst_fd_w;
  assign inst_x      = inst_x_q;
  assign inst_mw     = inst_mw_q;
  assign pc_fd       = pc_fd_q;
  assign pc_x        = pc_x_q;
  assign pc_mw       = pc_mw_q;
  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;

endmodule
`default_nettype wire
